// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the fetch/data memory port arbiter.
// Widths are reused by the core top level.
package mem_port_arbiter_pkg;
    localparam int ADDR_W  = 48;
    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY,
        RESP
    } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory handshake bundle around the arbiter.
// master = arbiter view, slave = core + memory view.
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; ();
    logic               i_req;
    logic [ADDR_W-1:0]  i_addr;
    logic               i_flush;
    logic [INSTR_W-1:0] i_rdata;
    logic               i_ready;

    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic [DATA_W-1:0]  d_rdata;
    logic               d_ready;

    logic               m_req;
    logic               m_we;
    logic [ADDR_W-1:0]  m_addr;
    logic [DATA_W-1:0]  m_wdata;
    logic [DATA_W-1:0]  m_rdata;
    logic               m_ack;

    modport master (
        input  i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, i_flush, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store.
// Data wins by default; a streak counter lets a waiting fetch through after MAX_D_STREAK data grants.
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int MAX_D_STREAK = 4
) (
    input logic                 clk,
    input logic                 n_reset,
    mem_port_arbiter_if.master  bus
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_q, state_d;
    logic [STREAK_W-1:0] streak_q;
    logic                flush_q;
    logic                grant_d, grant_i;
    logic                fetch_killed;

    assign fetch_killed = flush_q | bus.i_flush;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.i_req && streak_q == STREAK_MAX)) begin
                    state_d = DBUSY;
                    grant_d = 1'b1;
                end else if (bus.i_req && !bus.i_flush) begin
                    state_d = IBUSY;
                    grant_i = 1'b1;
                end
            end
            IBUSY:   if (bus.m_ack) state_d = RESP;
            DBUSY:   if (bus.m_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_rdata <= '0;
            bus.i_ready <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_ready <= 1'b0;
            streak_q    <= '0;
            flush_q     <= 1'b0;
        end else begin
            // ready outputs are single-cycle pulses
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            if (grant_d) begin
                bus.m_req   <= 1'b1;
                bus.m_we    <= bus.d_we;
                bus.m_addr  <= bus.d_addr;
                bus.m_wdata <= bus.d_wdata;
                if (!bus.i_req)                streak_q <= '0;
                else if (streak_q != STREAK_MAX) streak_q <= streak_q + STREAK_W'(1);
            end
            if (grant_i) begin
                bus.m_req   <= 1'b1;
                bus.m_we    <= 1'b0;
                bus.m_addr  <= bus.i_addr;
                bus.m_wdata <= '0;
                streak_q    <= '0;
            end
            if (state_q == IBUSY) begin
                flush_q <= fetch_killed;
                if (bus.m_ack) begin
                    bus.m_req <= 1'b0;
                    flush_q   <= 1'b0;
                    // a redirected fetch still completes on memory but is never delivered
                    if (!fetch_killed) begin
                        bus.i_ready <= 1'b1;
                        bus.i_rdata <= bus.m_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
                    end
                end
            end
            if (state_q == DBUSY && bus.m_ack) begin
                bus.m_req   <= 1'b0;
                bus.d_ready <= 1'b1;
                bus.d_rdata <= bus.m_we ? '0 : bus.m_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions
// plus hand sequences for streak fairness, flush, async reset and stray acks.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_i;
        bit          do_d;
        bit          is_store;
        logic [47:0] ia;
        logic [47:0] da;
        logic [63:0] wd;
        logic [63:0] rd;
        int          wt;
        bit          exp_fetch;
        logic [47:0] exp_addr;
        logic        exp_we;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        logic [47:0] a0;
        logic [63:0] w0;
        bus.i_req   = v.do_i;
        bus.i_addr  = v.ia;
        bus.d_req   = v.do_d;
        bus.d_we    = v.is_store;
        bus.d_addr  = v.da;
        bus.d_wdata = v.wd;
        tick();
        chk($sformatf("v%0d grant m_req", idx), 64'(bus.m_req), 64'd1);
        chk($sformatf("v%0d m_addr", idx), 64'(bus.m_addr), 64'(v.exp_addr));
        chk($sformatf("v%0d m_we", idx), 64'(bus.m_we), 64'(v.exp_we));
        if (v.exp_we) chk($sformatf("v%0d m_wdata", idx), bus.m_wdata, v.wd);
        a0 = bus.m_addr;
        w0 = bus.m_wdata;
        for (int w = 0; w < v.wt; w++) begin
            tick();
            chk($sformatf("v%0d wait%0d m_req", idx, w), 64'(bus.m_req), 64'd1);
            chk($sformatf("v%0d wait%0d m_addr", idx, w), 64'(bus.m_addr), 64'(a0));
            chk($sformatf("v%0d wait%0d m_wdata", idx, w), bus.m_wdata, w0);
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = v.rd;
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        chk($sformatf("v%0d i_ready", idx), 64'(bus.i_ready), 64'(v.exp_fetch));
        chk($sformatf("v%0d d_ready", idx), 64'(bus.d_ready), 64'(!v.exp_fetch));
        chk($sformatf("v%0d m_req drop", idx), 64'(bus.m_req), 64'd0);
        if (v.exp_fetch) chk($sformatf("v%0d i_rdata", idx), 64'(bus.i_rdata), v.exp_rdata);
        else             chk($sformatf("v%0d d_rdata", idx), bus.d_rdata, v.exp_rdata);
        tick();
        chk($sformatf("v%0d ready drop", idx), 64'({bus.i_ready, bus.d_ready}), 64'd0);
    endtask

    initial begin
        int t;
        int last;
        logic [47:0] exp_a;

        vecs[0] = '{1, 0, 0, 48'h1004, 48'h0, 64'h0, 64'hAAAA_BBBB_1111_2222, 0,
                    1, 48'h1004, 1'b0, 64'hAAAA_BBBB};
        vecs[1] = '{1, 0, 0, 48'h1000, 48'h0, 64'h0, 64'hAAAA_BBBB_1111_2222, 0,
                    1, 48'h1000, 1'b0, 64'h1111_2222};
        vecs[2] = '{0, 1, 1, 48'h0, 48'h2000, 64'hDEADBEEF_CAFEF00D, 64'h5555_6666_7777_8888, 3,
                    0, 48'h2000, 1'b1, 64'h0};
        vecs[3] = '{0, 1, 0, 48'h0, 48'h3008, 64'h0, 64'h0123_4567_89AB_CDEF, 1,
                    0, 48'h3008, 1'b0, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{1, 1, 0, 48'h1100, 48'h4000, 64'h0, 64'hFEDC_BA98_7654_3210, 0,
                    0, 48'h4000, 1'b0, 64'hFEDC_BA98_7654_3210};
        vecs[5] = '{1, 0, 0, 48'hFFFF_FFFF_FFFC, 48'h0, 64'h0, 64'h9999_0000_1234_5678, 2,
                    1, 48'hFFFF_FFFF_FFFC, 1'b0, 64'h9999_0000};

        bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0; bus.m_ack = 0;

        tick();
        tick();
        chk("reset m_req", 64'(bus.m_req), 64'd0);
        chk("reset readies", 64'({bus.i_ready, bus.d_ready, bus.m_we}), 64'd0);
        chk("reset m_addr", 64'(bus.m_addr), 64'd0);
        chk("reset rdata", bus.d_rdata | 64'(bus.i_rdata), 64'd0);
        n_reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // stray ack in IDLE: no pulse, and the next request is granted one edge later
        bus.m_ack = 1'b1;
        bus.m_rdata = '1;
        tick();
        bus.m_ack = 1'b0;
        chk("stray ack readies", 64'({bus.i_ready, bus.d_ready}), 64'd0);
        chk("stray ack m_req", 64'(bus.m_req), 64'd0);
        run_txn(vecs[3], 10);

        // flush during IBUSY with a data request waiting
        bus.i_req = 1'b1;
        bus.i_addr = 48'h7000;
        tick();
        chk("flush grant m_req", 64'(bus.m_req), 64'd1);
        bus.i_flush = 1'b1;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 48'h8000;
        tick();
        bus.i_flush = 1'b0;
        chk("flush m_req held", 64'(bus.m_req), 64'd1);
        chk("flush m_addr held", 64'(bus.m_addr), 64'h7000);
        tick();
        chk("flush m_req held 2", 64'(bus.m_req), 64'd1);
        bus.m_ack = 1'b1;
        bus.m_rdata = 64'h1111_1111_2222_2222;
        tick();
        bus.m_ack = 1'b0;
        bus.i_req = 1'b0;
        chk("flush i_ready suppressed", 64'(bus.i_ready), 64'd0);
        chk("flush m_req drop", 64'(bus.m_req), 64'd0);
        tick();
        chk("flush resp i_ready", 64'(bus.i_ready), 64'd0);
        tick();
        chk("after flush d grant", 64'(bus.m_req), 64'd1);
        chk("after flush d addr", 64'(bus.m_addr), 64'h8000);
        bus.m_ack = 1'b1;
        bus.m_rdata = 64'h0BAD_F00D_0000_0001;
        tick();
        bus.m_ack = 1'b0;
        bus.d_req = 1'b0;
        chk("after flush d_ready", 64'(bus.d_ready), 64'd1);
        chk("after flush d_rdata", bus.d_rdata, 64'h0BAD_F00D_0000_0001);
        tick();

        // async reset mid-DBUSY, with i_req waiting so the streak is nonzero
        bus.i_req = 1'b1;
        bus.i_addr = 48'h6004;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 48'h9000;
        bus.d_wdata = 64'h1;
        tick();
        chk("pre-reset m_req", 64'(bus.m_req), 64'd1);
        #2 n_reset = 1'b0;
        #1;
        chk("async reset m_req", 64'(bus.m_req), 64'd0);
        chk("async reset readies", 64'({bus.i_ready, bus.d_ready}), 64'd0);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();

        // both requesters held: D,D,D,D,I,D,D,D,D,I with 3-cycle grant spacing
        bus.i_req = 1'b1;
        bus.i_addr = 48'h6004;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 48'h5000;
        last = 0;
        for (int g = 0; g < 10; g++) begin
            t = 0;
            while (!bus.m_req && t < 20) begin
                tick();
                t++;
            end
            if (!bus.m_req) begin
                total++;
                bad++;
                $display("FAIL streak grant %0d: got no m_req expected grant within 20 cycles", g);
                break;
            end
            exp_a = (g % 5 == 4) ? 48'h6004 : 48'h5000;
            chk($sformatf("streak grant %0d addr", g), 64'(bus.m_addr), 64'(exp_a));
            if (g > 0) chk($sformatf("streak grant %0d spacing", g), 64'(cyc - last), 64'd3);
            last = cyc;
            bus.m_ack = 1'b1;
            bus.m_rdata = 64'hCCCC_DDDD_EEEE_FFFF;
            tick();
            bus.m_ack = 1'b0;
            chk($sformatf("streak grant %0d ready", g), 64'({bus.i_ready, bus.d_ready}),
                (g % 5 == 4) ? 64'd2 : 64'd1);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (48-bit address, 64-bit data) between the core's instruction-fetch path and its load/store path.
- Sits between the core's fetch/memory stages and the memory/bus interface.
- Data accesses win by default. A streak counter bounds fetch starvation.
- Owns request sequencing, address/data latching, instruction-word extraction and ready pulses back to each requester.

Parameters:
- ADDR_W, 48, address width on all ports
- DATA_W, 64, memory data width
- INSTR_W, 32, fetched instruction width
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is waiting

Ports:
- clk  input  1  core clock
- n_reset  input  1  asynchronous active-low reset
- i_req  input  1  fetch request; held until i_ready
- i_addr  input  ADDR_W  fetch address, 4-byte aligned
- i_flush  input  1  discard in-flight or pending fetch (branch redirect)
- i_rdata  output  INSTR_W  fetched instruction, valid with i_ready
- i_ready  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request; held until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address, 8-byte aligned
- d_wdata  input  DATA_W  store data
- d_rdata  output  DATA_W  load data, valid with d_ready
- d_ready  output  1  one-cycle data completion pulse
- m_req  output  1  memory request, held until m_ack
- m_we  output  1  memory write enable
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid with m_ack
- m_ack  input  1  memory completion, one cycle

Behaviour:
- Clock and reset: one clock, clk. n_reset is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, streak counter 0, flush flag 0.
- Reset mid-transaction returns the block to IDLE immediately. The memory side is expected to be reset by the same n_reset.
- States: IDLE, IBUSY, DBUSY, RESP.
- IDLE samples requests every edge. Grant decision:
  - d_req && !(i_req && streak==MAX_D_STREAK) → DBUSY; streak increments if i_req is high, else clears.
  - Otherwise i_req && !i_flush → IBUSY; streak clears.
  - Otherwise stay in IDLE.
- On grant, register m_addr/m_we/m_wdata from the winner and set m_req=1 on the same edge.
- m_we is 0 for fetches. m_wdata is don't-care for loads and fetches.
- IBUSY/DBUSY: hold m_req and all m_* outputs stable until m_ack is sampled high. On that edge:
  - m_req←0.
  - Capture the response (see below).
  - Assert the matching ready for exactly one cycle.
  - Go to RESP.
- Fetch response: i_rdata ← m_rdata[63:32] if the latched addr[2]=1, else m_rdata[31:0].
- Data response: d_rdata ← m_rdata. For stores, d_rdata←0 and d_ready is still pulsed.
- RESP: both ready outputs drop on the next edge; state → IDLE. No request is sampled in RESP, so a registered requester's updated req/addr is first seen one edge later.
- Minimum latency with zero-wait memory: req sampled at edge N, m_ack sampled at N+1, ready high N+1..N+2, next grant at N+3.
- Flush:
  - i_flush in IBUSY sets a flush flag. The access still completes on memory (no abort), but i_ready is suppressed at m_ack.
  - The flag clears on exit from IBUSY.
  - i_flush in IDLE blocks a fetch grant that cycle.
  - i_flush has no effect on data accesses.
- m_ack outside IBUSY/DBUSY is ignored.
- Simultaneous d_req and i_req with streak<MAX_D_STREAK: data wins.
- The streak counter saturates at MAX_D_STREAK. Width is clog2(MAX_D_STREAK+1).

Decomposition:
- Shared package holds:
  - arb_state_t enum (IDLE, IBUSY, DBUSY, RESP).
  - ADDR_W/DATA_W/INSTR_W constants, reused by the core top.
- No sub-module. Single FSM plus datapath registers.

Test Plan:
- Fetch only, i_addr=0x1004, m_ack one cycle after m_req, m_rdata=0xAAAA_BBBB_1111_2222 → i_rdata=0xAAAABBBB, i_ready high one cycle, m_we=0, next grant no earlier than 3 cycles after the first.
- Store, d_addr=0x2000, d_wdata=0xDEADBEEF_CAFEF00D, m_ack after 3 wait cycles → m_req/m_addr/m_wdata stable for all 4 cycles, m_we=1, d_ready one pulse, d_rdata=0.
- d_req and i_req held together continuously, MAX_D_STREAK=4 → grant order D,D,D,D,I,D,D,D,D,I.
- Fetch in IBUSY, i_flush pulsed before m_ack → m_req held until m_ack, i_ready never asserts, next IDLE cycle serves a pending d_req.
- n_reset dropped mid-DBUSY → m_req, d_ready, i_ready go 0 without a clock. After release, a fresh d_req completes normally with streak=0.
- Spurious m_ack in IDLE → no ready pulse, no state change.
